// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// input_conditioner : synchronises and glitch-filters three pins, emits edge
//                     pulses, counts trigger/watchdog events. Rev 1.0
// ============================================================================

module input_conditioner_chan #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_ANY    = 1'b0
) (
    input  logic        clk,
    input  logic        peripheral_aresetn,
    input  logic        i_raw,
    input  logic [15:0] i_len,
    output logic        o_clean,
    output logic        o_pulse,
    output logic        o_check
);
    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_CHECK_HIGH  = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_CHECK_LOW   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_cnt;
    logic [15:0]            w_cnt_nxt;
    logic                   r_clean;
    logic                   w_clean_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;
    logic                   w_s;
    logic [15:0]            w_len;
    logic [16:0]            w_cnt_inc;
    logic                   w_done;
    logic                   w_len_one;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_len     = (i_len == 16'd0) ? 16'd1 : i_len;
    assign w_len_one = (w_len == 16'd1);
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    // The counter holds samples already seen; this edge's sample makes it one more.
    assign w_done    = (w_cnt_inc >= {1'b0, w_len});

    always_ff @(posedge clk) begin
        if (!peripheral_aresetn) begin
            r_sync  <= '0;
            r_state <= ST_STABLE_LOW;
            r_cnt   <= 16'd0;
            r_clean <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_STABLE_LOW: begin
                if (w_s) begin
                    if (w_len_one) begin
                        w_state_nxt = ST_STABLE_HIGH;
                        w_clean_nxt = 1'b1;
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_state_nxt = ST_CHECK_HIGH;
                        w_cnt_nxt   = 16'd1;
                    end
                end
            end
            ST_CHECK_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_cnt_nxt   = 16'd0;
                end else if (w_done) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_clean_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[15:0];
                end
            end
            ST_STABLE_HIGH: begin
                if (!w_s) begin
                    if (w_len_one) begin
                        w_state_nxt = ST_STABLE_LOW;
                        w_clean_nxt = 1'b0;
                        w_pulse_nxt = EDGE_ANY;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_state_nxt = ST_CHECK_LOW;
                        w_cnt_nxt   = 16'd1;
                    end
                end
            end
            ST_CHECK_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_cnt_nxt   = 16'd0;
                end else if (w_done) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_clean_nxt = 1'b0;
                    w_pulse_nxt = EDGE_ANY;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[15:0];
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_LOW;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    assign o_clean = r_clean;
    assign o_pulse = r_pulse;
    assign o_check = (r_state == ST_CHECK_HIGH) || (r_state == ST_CHECK_LOW);
endmodule

module input_conditioner #(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic        clk,
    input  logic        peripheral_aresetn,
    input  logic [15:0] filter_cfg,
    input  logic        clear_counts,
    input  logic        trigger_raw,
    input  logic        watchdog_raw,
    input  logic        instant_reset_raw,
    output logic        trigger_clean,
    output logic        watchdog_clean,
    output logic        instant_reset_clean,
    output logic        trigger_rise,
    output logic        watchdog_edge,
    output logic        instant_reset_rise,
    output logic [31:0] trigger_count,
    output logic [31:0] watchdog_count,
    output logic [31:0] cond_sts
);
    // Channel order: 0 trigger, 1 watchdog, 2 instant_reset; only watchdog pulses on both edges.
    localparam logic [2:0] c_EDGE_ANY_MASK = 3'b010;

    logic [2:0]  w_raw;
    logic [2:0]  w_clean;
    logic [2:0]  w_pulse;
    logic [2:0]  w_check;
    logic [31:0] r_trigger_count;
    logic [31:0] r_watchdog_count;

    assign w_raw = {instant_reset_raw, watchdog_raw, trigger_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            input_conditioner_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE_ANY    (c_EDGE_ANY_MASK[gi])
            ) u_chan (
                .clk                (clk),
                .peripheral_aresetn (peripheral_aresetn),
                .i_raw              (w_raw[gi]),
                .i_len              (filter_cfg),
                .o_clean            (w_clean[gi]),
                .o_pulse            (w_pulse[gi]),
                .o_check            (w_check[gi])
            );
        end
    endgenerate

    // Counters absorb the registered pulse during the cycle it is visible.
    always_ff @(posedge clk) begin
        if (!peripheral_aresetn) begin
            r_trigger_count  <= 32'd0;
            r_watchdog_count <= 32'd0;
        end else if (clear_counts) begin
            r_trigger_count  <= {31'd0, w_pulse[0]};
            r_watchdog_count <= {31'd0, w_pulse[1]};
        end else begin
            if (w_pulse[0]) r_trigger_count  <= r_trigger_count + 32'd1;
            if (w_pulse[1]) r_watchdog_count <= r_watchdog_count + 32'd1;
        end
    end

    assign trigger_clean       = w_clean[0];
    assign watchdog_clean      = w_clean[1];
    assign instant_reset_clean = w_clean[2];
    assign trigger_rise        = w_pulse[0];
    assign watchdog_edge       = w_pulse[1];
    assign instant_reset_rise  = w_pulse[2];
    assign trigger_count       = r_trigger_count;
    assign watchdog_count      = r_watchdog_count;
    assign cond_sts            = {26'd0, w_check, w_clean};
endmodule
`default_nettype wire

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per channel; legal range 2..4.
REQ-002 clk  input  1  system clock, 125 MHz.
REQ-003 peripheral_aresetn  input  1  reset; synchronous, active-low.
REQ-004 filter_cfg  input  16  filter length N in cycles; value 0 SHALL be treated as 1.
REQ-005 clear_counts  input  1  synchronous clear of both event counters.
REQ-006 trigger_raw, watchdog_raw, instant_reset_raw  input  1 each  asynchronous pin levels.
REQ-007 trigger_clean, watchdog_clean, instant_reset_clean  output  1 each  filtered levels that feed the reset manager.
REQ-008 trigger_rise  output  1  one-cycle pulse on a rising edge of trigger_clean.
REQ-009 watchdog_edge  output  1  one-cycle pulse on any edge of watchdog_clean.
REQ-010 instant_reset_rise  output  1  one-cycle pulse on a rising edge of instant_reset_clean.
REQ-011 trigger_count  output  32  count of trigger_rise pulses.
REQ-012 watchdog_count  output  32  count of watchdog_edge pulses.
REQ-013 cond_sts  output  32  status word.

Function
REQ-014 Each channel SHALL pass its raw input through a SYNC_STAGES-deep flip-flop chain; the last stage output is s.
REQ-015 Each channel SHALL run a 4-state FSM: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; each channel has its own 16-bit run counter.
- STABLE_LOW, s=1 -> CHECK_HIGH, counter=1.
- STABLE_HIGH, s=0 -> CHECK_LOW, counter=1.
REQ-016 In a CHECK state the FSM SHALL behave as follows:
- s equals the pending level and counter >= N -> commit to the matching STABLE state and toggle the clean output on that edge.
- s equals the pending level and counter < N -> counter increments.
- s reverts -> return to the previous STABLE state, counter=0, clean output unchanged.
REQ-017 With N=1, the clean output SHALL change on the first edge at which s differs from the clean output, without visiting a CHECK state.
REQ-018 Latency from a raw level change (stable thereafter) to the clean output change SHALL be exactly SYNC_STAGES+N clock cycles.
REQ-019 A change of filter_cfg during a CHECK state SHALL take effect immediately; if counter >= the new N, the channel commits on the next edge.
REQ-020 Any raw pulse shorter than N cycles at s SHALL produce no clean-output change and no pulse.
REQ-021 Edge pulses SHALL be registered and asserted for exactly one cycle, in the same cycle the clean output first shows the new level.
REQ-022 trigger_count SHALL increment on each trigger_rise; watchdog_count SHALL increment on each watchdog_edge.
REQ-023 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 clear_counts=1 SHALL load 0 into both counters; if a pulse occurs in the same cycle, the affected counter SHALL load 1.
REQ-025 cond_sts bit assignment SHALL be:
- [0] trigger_clean, [1] watchdog_clean, [2] instant_reset_clean.
- [3] trigger CHECK active, [4] watchdog CHECK active, [5] instant_reset CHECK active.
- [31:6] zero.

Reset
REQ-026 While peripheral_aresetn=0 at a clock edge, the following SHALL be forced low/zero: all synchronizer stages, all clean outputs, all pulses, both counters, all run counters and cond_sts; all FSMs SHALL enter STABLE_LOW.
REQ-027 A reset asserted mid-CHECK SHALL abort the check with no pulse.
REQ-028 After reset release with a raw input held high, the clean output SHALL rise after the full SYNC_STAGES+N cycles and SHALL emit its rising pulse.
REQ-029 Reset SHALL take precedence over clear_counts and over all input activity.

Verification
REQ-030 N=4, SYNC_STAGES=2; trigger_raw 0->1 held -> trigger_clean=1 and trigger_rise high for 1 cycle exactly 6 cycles later; trigger_count=1.
REQ-031 N=4; watchdog_raw high for 3 cycles then low -> watchdog_clean stays 0, no watchdog_edge, cond_sts[4] high during the check, watchdog_count=0.
REQ-032 N=1; watchdog_raw toggled every 10 cycles for 20 toggles -> 20 watchdog_edge pulses, each 3 cycles after its toggle; watchdog_count=20.
REQ-033 trigger_count preloaded to 0xFFFFFFFF via 2^32-1 events (or a forced value), then one more trigger_rise -> trigger_count=0; then clear_counts coincident with a trigger_rise -> trigger_count=1.
REQ-034 N=100; instant_reset_raw high, reset asserted at check cycle 50 and released -> no pulse during reset; instant_reset_clean=1 exactly 102 cycles after release.
REQ-035 N=20; change filter_cfg to 5 while trigger is in CHECK_HIGH with counter=8 -> trigger commits on the next edge.
